// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared types and constants for the HI/LO divide sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH          = 32;
  localparam int DIV_SETTLE_CYCLES  = 4;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_sign_fix.sv
// ============================================================================
// Module  : div_sign_fix
// Purpose : Applies two's-complement sign correction to an unsigned quotient
//           and remainder (quotient takes sign_a^sign_b, remainder sign_a).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] div_q_i,
  input  logic [WIDTH-1:0] div_r_i,
  input  logic             sign_a_i,
  input  logic             sign_b_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic w_neg_q;

  assign w_neg_q = sign_a_i ^ sign_b_i;
  assign quot_o  = w_neg_q  ? (~div_q_i + C_ONE) : div_q_i;
  assign rem_o   = sign_a_i ? (~div_r_i + C_ONE) : div_r_i;

endmodule : div_sign_fix

`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
// ============================================================================
// Module  : div_hilo_ctrl
// Purpose : Multicycle DIV/DIVU sequencer around a combinational unsigned
//           divider core; owns the architectural HI/LO registers.
//           Optional abort input enabled by defining DIV_ABORT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int SETTLE_CYCLES = DIV_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
`ifdef DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_DIV0_Q   = {WIDTH{DIV0_QUOTIENT[0]}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             zdiv_q, zdiv_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             w_sign_a, w_sign_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_fix_q, w_fix_r;

  assign w_sign_a = signed_op & a[WIDTH-1];
  assign w_sign_b = signed_op & b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (~a + C_ONE) : a;
  assign w_mag_b  = w_sign_b ? (~b + C_ONE) : b;

  // On divide-by-zero, re-signing the stored |a| reproduces the original a for HI.
  assign w_rem_in = zdiv_q ? div_a_q : div_r;

  div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .div_q_i  (div_q),
    .div_r_i  (w_rem_in),
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .quot_o   (w_fix_q),
    .rem_o    (w_fix_r)
  );

`ifdef DIV_ABORT_EN
  logic dbz_shadow_q, dbz_shadow_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    zdiv_d   = zdiv_q;
    dbz_d    = dbz_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef DIV_ABORT_EN
    dbz_shadow_d = dbz_shadow_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        if (start) begin
          sign_a_d = w_sign_a;
          sign_b_d = w_sign_b;
          div_a_d  = w_mag_a;
          div_b_d  = w_mag_b;
          zdiv_d   = (b == '0);
          dbz_d    = 1'b0;
          cnt_d    = C_CNT_LOAD;
`ifdef DIV_ABORT_EN
          dbz_shadow_d = dbz_q;
`endif
          state_d  = (b == '0) ? FIX : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - C_CNT_ONE;
      end
      FIX: begin
        lo_d    = zdiv_q ? C_DIV0_Q : w_fix_q;
        hi_d    = w_fix_r;
        dbz_d   = zdiv_q;
        state_d = DONE;
      end
      DONE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef DIV_ABORT_EN
    // Abort beats the FIX write; HI/LO are untouched while busy, so only the flag needs restoring.
    if (abort && ((state_q == WAIT) || (state_q == FIX))) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_shadow_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zdiv_q   <= 1'b0;
      dbz_q    <= 1'b0;
      div_a_q  <= '0;
      div_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      zdiv_q   <= zdiv_d;
      dbz_q    <= dbz_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

`ifdef DIV_ABORT_EN
  always_ff @(posedge clk) begin
    if (reset) dbz_shadow_q <= 1'b0;
    else       dbz_shadow_q <= dbz_shadow_d;
  end
`endif

  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == WAIT) || (state_q == FIX);
  assign done        = (state_q == DONE);

endmodule : div_hilo_ctrl

`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
// ============================================================================
// Module  : tb_div_hilo_ctrl
// Purpose : Directed self-checking bench for div_hilo_ctrl with a behavioural
//           unsigned divider core (DIV_ABORT_EN adds the abort scenario).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_hilo_ctrl;

  localparam int W  = 32;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         reset, start, signed_op, hi_we, lo_we, abort;
  logic [W-1:0] a, b, wr_data;
  logic [W-1:0] div_a, div_b, div_q, div_r, hi, lo;
  logic         busy, done, div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign div_q = (div_b == '0) ? '1    : div_a / div_b;
  assign div_r = (div_b == '0) ? div_a : div_a % div_b;

  div_hilo_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .a           (a),
    .b           (b),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_q       (div_q),
    .div_r       (div_r),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wr_data     (wr_data),
`ifdef DIV_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE and checks latency, busy span and results.
  task automatic run_div(input string tag, input logic s, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input logic exp_dz, input int exp_lat);
    int lat;
    int bsy;
    start = 1'b1; signed_op = s; a = av; b = bv;
    step();
    start = 1'b0;
    lat = 0;
    bsy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (busy) bsy++;
    end
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_busy_cycles"}, W'(bsy), W'(exp_lat));
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_dbz"}, W'(div_by_zero), W'(exp_dz));
    step();
    check({tag, "_done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    int lat;
    int ndone;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    abort = 1'b0; a = '0; b = '0; wr_data = '0;
    repeat (3) step();
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_div_a", div_a, '0);
    check("rst_div_b", div_b, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_dbz", W'(div_by_zero), W'(0));
    reset = 1'b0;
    step();

    run_div("div_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, SC + 1);
    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, SC + 1);
    run_div("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, SC + 1);
    run_div("div_7_0", 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1);

    // The next accepted start must clear the divide-by-zero flag immediately.
    start = 1'b1; signed_op = 1'b1; a = 32'd6; b = 32'd3;
    step();
    start = 1'b0;
    check("dbz_clear_on_start", W'(div_by_zero), W'(0));
    check("div_6_3_div_a", div_a, 32'd6);
    lat = 0;
    while (!done && lat < 40) begin step(); lat++; end
    check("div_6_3_latency", W'(lat), W'(SC + 1));
    check("div_6_3_lo", lo, 32'd2);
    check("div_6_3_hi", hi, 32'd0);
    step();

    run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, SC + 1);

    lo_we = 1'b1; wr_data = 32'h0000_ABCD;
    step();
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h0000_ABCD);

    // MTHI with start on the same IDLE edge lands, then WAIT-time MTHI and a second start are dropped.
    start = 1'b1; signed_op = 1'b1; a = 32'd100; b = 32'd7; hi_we = 1'b1; wr_data = 32'h0000_5555;
    step();
    start = 1'b0; hi_we = 1'b0;
    check("mthi_with_start", hi, 32'h0000_5555);
    check("wait_div_a", div_a, 32'd100);
    check("wait_div_b", div_b, 32'd7);
    hi_we = 1'b1; wr_data = 32'h0000_1234; start = 1'b1; a = 32'd9; b = 32'd2;
    step();
    hi_we = 1'b0; start = 1'b0;
    check("mthi_wait_dropped", hi, 32'h0000_5555);
    check("wait_div_a_stable", div_a, 32'd100);
    lat = 1;
    while (!done && lat < 40) begin step(); lat++; end
    check("wait_wr_latency", W'(lat), W'(SC + 1));
    check("wait_wr_hi", hi, 32'd2);
    check("wait_wr_lo", lo, 32'd14);
    ndone = 0;
    repeat (12) begin step(); if (done) ndone++; end
    check("second_start_ignored", W'(ndone), W'(0));

    // Reset in the middle of WAIT.
    start = 1'b1; signed_op = 1'b0; a = 32'd50; b = 32'd3;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    check("midrst_div_a", div_a, '0);
    ndone = 0;
    repeat (10) begin step(); if (done || busy) ndone++; end
    check("midrst_idle", W'(ndone), W'(0));

`ifdef DIV_ABORT_EN
    run_div("abt_setup", 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1);
    start = 1'b1; signed_op = 1'b0; a = 32'd50; b = 32'd3;
    step();
    start = 1'b0;
    check("abt_dbz_cleared", W'(div_by_zero), W'(0));
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_busy", W'(busy), W'(0));
    check("abt_hi", hi, 32'd7);
    check("abt_lo", lo, 32'hFFFF_FFFF);
    check("abt_dbz_restored", W'(div_by_zero), W'(1));
    ndone = 0;
    repeat (10) begin step(); if (done) ndone++; end
    check("abt_no_done", W'(ndone), W'(0));
    run_div("abt_after", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0, SC + 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_hilo_ctrl

`default_nettype wire
